// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and divide special-case constants.
package muldiv_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StRun,
        StFinish,
        StDone
    } state_e;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 divide iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it fits.
module muldiv_div_step (
    input  logic [31:0] rem_i,
    input  logic        bit_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic        quot_o
);

    logic [32:0] shifted;
    logic [31:0] diff;

    // Trial subtract on the 33-bit shifted remainder.
    always_comb begin
        shifted = {rem_i, bit_i};
        quot_o  = (shifted >= {1'b0, divisor_i});
        // When the subtract succeeds the difference is below the divisor, so 32 bits suffice.
        diff    = shifted[31:0] - divisor_i;
        rem_o   = quot_o ? diff : shifted[31:0];
    end

endmodule

// File: rtl/muldiv.sv
// Multi-cycle RV32M multiply/divide unit with start/busy/done handshake.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single combinational
// multiply in SETUP instead of the 32-cycle shift-add loop.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] source,
    input  logic [WIDTH-1:0] arg_1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic        signed_a, signed_b, neg_a_w, neg_b_w, is_div, div_ovf;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [31:0] div_rem;
    logic        div_q;
    logic [63:0] fin_prod;
    logic [31:0] fin_quot, fin_rem;

    // Operand sign handling, only meaningful while in SETUP with raw operands.
    assign signed_a = (op_q == MULDIV_OP_MULH) || (op_q == MULDIV_OP_MULHSU) ||
                      (op_q == MULDIV_OP_DIV)  || (op_q == MULDIV_OP_REM);
    assign signed_b = (op_q == MULDIV_OP_MULH) || (op_q == MULDIV_OP_DIV) ||
                      (op_q == MULDIV_OP_REM);
    assign neg_a_w  = signed_a & a_q[31];
    assign neg_b_w  = signed_b & b_q[31];
    assign mag_a    = neg_a_w ? -a_q : a_q;
    assign mag_b    = neg_b_w ? -b_q : b_q;
    assign is_div   = op_q[2];
    assign div_ovf  = ((op_q == MULDIV_OP_DIV) || (op_q == MULDIV_OP_REM)) &&
                      (a_q == INT_MIN) && (b_q == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] fast_a, fast_b, fast_prod;
    // Sign-extended 33-bit operands; the low 64 product bits are all that matter.
    assign fast_a    = {{32{neg_a_w}}, a_q};
    assign fast_b    = {{32{neg_b_w}}, b_q};
    assign fast_prod = fast_a * fast_b;
`endif

    muldiv_div_step u_div_step (
        .rem_i     (acc_q[63:32]),
        .bit_i     (acc_q[31]),
        .divisor_i (b_q),
        .rem_o     (div_rem),
        .quot_o    (div_q)
    );

    // Next-state, datapath and result selection.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, b_q};
        fin_prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        fin_quot = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
        fin_rem  = neg_a_q ? -acc_q[63:32] : acc_q[63:32];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    a_d     = source;
                    b_d     = arg_1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                neg_a_d = neg_a_w;
                neg_b_d = neg_b_w;
                a_d     = mag_a;
                b_d     = mag_b;
                acc_d   = {32'h0, mag_a};
                cnt_d   = '0;
                state_d = StRun;
                // Special cases preload acc with the final words and clear the
                // sign flags, so FINISH selects them like any other result.
                if (is_div && (b_q == 32'h0)) begin
                    acc_d   = {a_q, DIV_ZERO_QUOT};
                    neg_a_d = 1'b0;
                    neg_b_d = 1'b0;
                    state_d = StFinish;
                end else if (div_ovf) begin
                    acc_d   = {32'h0, INT_MIN};
                    neg_a_d = 1'b0;
                    neg_b_d = 1'b0;
                    state_d = StFinish;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!is_div) begin
                    acc_d   = fast_prod;
                    neg_a_d = 1'b0;
                    neg_b_d = 1'b0;
                    state_d = StFinish;
                end
`endif
            end
            StRun: begin
                if (is_div) begin
                    acc_d = {div_rem, acc_q[30:0], div_q};
                end else if (acc_q[0]) begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end else begin
                    acc_d = {1'b0, acc_q[63:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                unique case (op_q)
                    MULDIV_OP_MUL:    result_d = fin_prod[31:0];
                    MULDIV_OP_MULH,
                    MULDIV_OP_MULHSU,
                    MULDIV_OP_MULHU:  result_d = fin_prod[63:32];
                    MULDIV_OP_DIV,
                    MULDIV_OP_DIVU:   result_d = fin_quot;
                    default:          result_d = fin_rem;
                endcase
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
Multi-cycle RV32M multiply/divide unit. It complements the single-cycle integer ALU: same operand naming, with an explicit start/busy/done handshake instead of combinational output. The execute stage launches one operation, stalls while busy is high, then writes back result when done pulses.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start  input  1  launch request; sampled only in IDLE
- op  input  3  funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- source  input  32  rs1 operand
- arg_1  input  32  rs2 operand
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result is valid during it
- result  output  32  registered result; holds until the next done

Behaviour:
- Reset (reset==0 at a clk edge):
  - state becomes IDLE; busy=0, done=0, result=0; all internal registers cleared.
  - A reset asserted mid-operation aborts it with no done pulse.
- States: IDLE, SETUP, RUN, FINISH, DONE.
- IDLE:
  - start==1 latches op, source and arg_1, then goes to SETUP.
  - start while not in IDLE (including DONE) is ignored; the operands are not latched.
- SETUP:
  - Signed ops (MULH, DIV, REM; rs1 of MULHSU) store magnitudes plus a sign flag.
  - DIV/DIVU/REM/REMU with arg_1==0 short-circuit to DIV/DIVU result 0xFFFFFFFF and REM/REMU result = source, then go to DONE.
  - DIV/REM with source==0x80000000 and arg_1==0xFFFFFFFF short-circuit to DIV 0x80000000 and REM 0, then go to DONE.
  - Otherwise the iteration counter is cleared and the state goes to RUN.
- RUN: exactly 32 cycles, then FINISH.
  - Multiply: shift-add over a 64-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring radix-2, one quotient bit per cycle (trial subtract of the 33-bit partial remainder).
- FINISH:
  - Apply sign correction: the product is negated if the sign flags differ. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - Select the low or high product word, quotient or remainder per op. Register result, then go to DONE.
- DONE: done=1 for this single cycle, then IDLE.
- Latency, with start sampled at edge 0:
  - normal op: done is high in the cycle after edge 34;
  - short-circuit: done is high in the cycle after edge 2.
- Result arithmetic is modulo 2^32; there are no exceptions and no flags.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: SETUP computes the full 64-bit product with one combinational signed/unsigned 33x33 multiply, registers the selected word, and goes straight to DONE. All four multiply ops then have 2-edge latency. Divide is unchanged.
- Undefined: multiply uses the 32-cycle shift-add path, with latency identical to divide. No hardware multiplier is inferred.

Decomposition:
- Shared package/include holds:
  - op encodings MULDIV_OP_MUL … MULDIV_OP_REMU;
  - state encodings;
  - constants DIV_ZERO_QUOT = 0xFFFFFFFF and INT_MIN = 0x80000000.
- Natural sub-module: muldiv_div_step, a combinational single restoring-divide iteration. Inputs are the partial remainder, dividend bit and divisor; outputs are the next remainder and quotient bit. It is instantiated once in muldiv.

Test Plan:
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB. busy rises after edge 0; done pulses one cycle after edge 34 (edge 2 with MULDIV_FAST_MUL_EN).
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD;
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF;
  - DIVU 100 / 7 → 14;
  - REMU 100 / 7 → 2.
- Divide special cases, each with done one cycle after edge 2:
  - DIV 5 / 0 → 0xFFFFFFFF;
  - REMU 5 / 0 → 5;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000;
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Handshake and reset:
  - A second start with new operands at edge 10 is ignored and the first result is unchanged.
  - reset=0 at edge 20 of a DIV → busy=0, done=0, result=0, with no done pulse afterward.
